// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage:
// reset address, fetch-buffer entry layout and exception encoding.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  localparam int FS_TO_DS_BUS_WD = 65;

  typedef enum logic {
    EXCP_NONE = 1'b0,
    EXCP_ADEF = 1'b1
  } excp_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    excp_e       excp;
  } fs_entry_t;

  function automatic fs_entry_t mk_entry(
    input logic [31:0] pc,
    input logic [31:0] inst,
    input excp_e       excp
  );
    fs_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    e.excp = excp;
    return e;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous fetch buffer; flush wins over push.
// Head is combinational from the read pointer.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Fetch front end: PC, SRAM issue with credit check, fetch buffer.
// Define IF_ADEF_EN to raise ADEF on misaligned fetch addresses.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_excp
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] issued_pc;
  logic [31:0] addr;
  logic        inflight;
  logic        issue;
  logic        push;
  logic        pop;
  logic        credit_ok;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] credit_base;
  logic [CW:0]   credit;
  fs_entry_t   push_entry;
  fs_entry_t   head;
  logic [FS_TO_DS_BUS_WD-1:0] head_bits;

  assign addr = br_taken ? br_target : pc;

  assign fs_to_ds_valid = !reset && !br_taken
                       && (fifo_count != '0);
  assign pop = fs_to_ds_valid && ds_allowin;

  // Occupancy next cycle if we issue now; a redirect empties the buffer.
  assign credit_base = br_taken ? '0 : fifo_count;
  assign credit = {1'b0, credit_base}
                + (CW+1)'(inflight)
                - (CW+1)'(pop);
  assign credit_ok = credit < (CW+1)'(FIFO_DEPTH);

  assign push = inflight && !br_taken;

`ifdef IF_ADEF_EN
  logic halted;
  logic adef_q;
  logic misaligned;

  assign misaligned = addr[1:0] != 2'b00;
  assign issue = !reset && credit_ok
              && !(halted && !br_taken);
  assign inst_sram_en = issue && !misaligned;

  assign push_entry = adef_q
    ? mk_entry(issued_pc, 32'h0, EXCP_ADEF)
    : mk_entry(issued_pc, inst_sram_rdata, EXCP_NONE);

  assign fs_to_ds_excp = fs_to_ds_valid
                      && (head.excp == EXCP_ADEF);

  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
      adef_q <= 1'b0;
    end else begin
      adef_q <= issue && misaligned;
      if (issue && misaligned) begin
        halted <= 1'b1;
      end else if (br_taken) begin
        halted <= 1'b0;
      end
    end
  end
`else
  logic unused_excp;

  assign issue = !reset && credit_ok;
  assign inst_sram_en = issue;
  assign push_entry = mk_entry(
    issued_pc, inst_sram_rdata, EXCP_NONE);
  assign fs_to_ds_excp = 1'b0;
  assign unused_excp = head.excp;
`endif

  always_comb begin
    pc_next = pc;
    if (issue) begin
      pc_next = addr + 32'd4;
    end
`ifdef IF_ADEF_EN
    // A faulting PC is parked until the next redirect.
    if (issue && misaligned) begin
      pc_next = addr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
    end else begin
      pc       <= pc_next;
      inflight <= issue;
      if (issue) begin
        issued_pc <= addr;
      end
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FS_TO_DS_BUS_WD)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (br_taken),
    .din   (push_entry),
    .count (fifo_count),
    .head  (head_bits)
  );

  assign head = fs_entry_t'(head_bits);

  assign fs_to_ds_pc     = head.pc;
  assign fs_to_ds_inst   = head.inst;
  assign inst_sram_addr  = addr;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected fetch stream
// per redirect segment, checked by a negedge monitor.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int FIFO_DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_to_ds_excp;

  if_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .ds_allowin      (ds_allowin),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_pc     (fs_to_ds_pc),
    .fs_to_ds_inst   (fs_to_ds_inst),
    .fs_to_ds_excp   (fs_to_ds_excp)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [31:0] fetch_exp;
  logic        stalled = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  // Instruction SRAM: one-cycle latency, garbage when idle.
  always @(posedge clk) begin
    if (inst_sram_en)
      inst_sram_rdata <= memf(inst_sram_addr);
    else
      inst_sram_rdata <= $urandom;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // New fetch segment: everything delivered from here on
  // is the sequential stream starting at pc.
  task automatic redirect_model(input logic [31:0] pc);
    exp_t e;
    exp_q.delete();
`ifdef IF_ADEF_EN
    if (pc[1:0] != 2'b00) begin
      e.pc = pc;
      e.inst = 32'h0;
      e.excp = 1'b1;
      exp_q.push_back(e);
      return;
    end
`endif
    for (int i = 0; i < 256; i++) begin
      e.pc = pc + 32'(4 * i);
      e.inst = memf(e.pc);
      e.excp = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rst_en", {31'b0, inst_sram_en}, 0);
      check("rst_valid", {31'b0, fs_to_ds_valid}, 0);
      fetch_exp = RESET_PC;
      stalled = 1'b0;
    end else if (br_taken) begin
      check("br_valid", {31'b0, fs_to_ds_valid}, 0);
`ifdef IF_ADEF_EN
      if (br_target[1:0] != 2'b00) begin
        check("adef_en", {31'b0, inst_sram_en}, 0);
        stalled = 1'b1;
      end else
`endif
      begin
        check("br_en", {31'b0, inst_sram_en}, 1);
        check("br_addr", inst_sram_addr, br_target);
        fetch_exp = br_target + 32'd4;
        stalled = 1'b0;
      end
    end else begin
      if (stalled) begin
        check("stall_en", {31'b0, inst_sram_en}, 0);
      end else if (inst_sram_en) begin
        check("fetch_addr", inst_sram_addr, fetch_exp);
        fetch_exp = fetch_exp + 32'd4;
      end
      check("no_overflow",
            {31'b0, dut.push && !dut.pop
             && (dut.fifo_count == FIFO_DEPTH)}, 0);
      if (fs_to_ds_valid && ds_allowin) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("pop_unexpected", fs_to_ds_pc, 32'hx);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", fs_to_ds_pc, e.pc);
          check("pop_inst", fs_to_ds_inst, e.inst);
          check("pop_excp", {31'b0, fs_to_ds_excp},
                {31'b0, e.excp});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    int since;
    int base;
    reset = 1'b1;
    br_taken = 1'b0;
    br_target = 32'h0;
    ds_allowin = 1'b1;
    redirect_model(RESET_PC);
    step();
    step();

    // Start-up latency and streaming
    reset = 1'b0;
    #2;
    check("t0_en", {31'b0, inst_sram_en}, 1);
    check("t0_addr", inst_sram_addr, RESET_PC);
    check("t0_valid", {31'b0, fs_to_ds_valid}, 0);
    step();
    #2;
    check("t1_addr", inst_sram_addr, RESET_PC + 4);
    check("t1_valid", {31'b0, fs_to_ds_valid}, 0);
    step();
    #2;
    check("t2_valid", {31'b0, fs_to_ds_valid}, 1);
    check("t2_pc", fs_to_ds_pc, RESET_PC);
    repeat (8) begin
      step();
      #2;
      check("stream_valid", {31'b0, fs_to_ds_valid}, 1);
    end

    // Back-pressure: buffer fills, fetch stops, head held
    step();
    ds_allowin = 1'b0;
    repeat (5) begin
      #2;
      check("bp_en", {31'b0, inst_sram_en}, 0);
      check("bp_valid", {31'b0, fs_to_ds_valid}, 1);
      check("bp_head", fs_to_ds_pc, exp_q[0].pc);
      step();
    end

    // Redirect while full
    br_taken = 1'b1;
    br_target = 32'h1c000100;
    redirect_model(br_target);
    #2;
    check("full_br_valid", {31'b0, fs_to_ds_valid}, 0);
    check("full_br_addr", inst_sram_addr, 32'h1c000100);
    step();
    br_taken = 1'b0;
    ds_allowin = 1'b1;
    #2;
    check("post_br_valid", {31'b0, fs_to_ds_valid}, 0);
    step();
    #2;
    check("post_br_valid2", {31'b0, fs_to_ds_valid}, 1);
    check("post_br_pc", fs_to_ds_pc, 32'h1c000100);
    repeat (6) step();

    // Back-to-back redirects with responses in flight
    br_taken = 1'b1;
    br_target = 32'h1c000400;
    redirect_model(br_target);
    step();
    br_target = 32'h1c000800;
    redirect_model(br_target);
    step();
    br_taken = 1'b0;
    repeat (6) step();

    // Address wrap
    br_taken = 1'b1;
    br_target = 32'hfffffff8;
    redirect_model(br_target);
    step();
    br_taken = 1'b0;
    repeat (8) step();

    // Reset mid-stream
    reset = 1'b1;
    redirect_model(RESET_PC);
    step();
    reset = 1'b0;
    #2;
    check("rs_en", {31'b0, inst_sram_en}, 1);
    check("rs_addr", inst_sram_addr, RESET_PC);
    check("rs_valid", {31'b0, fs_to_ds_valid}, 0);
    repeat (6) step();

`ifdef IF_ADEF_EN
    br_taken = 1'b1;
    br_target = 32'h1c000102;
    redirect_model(br_target);
    step();
    br_taken = 1'b0;
    repeat (12) step();
    check("adef_drained", 32'(exp_q.size()), 0);
    br_taken = 1'b1;
    br_target = 32'h1c000200;
    redirect_model(br_target);
    step();
    br_taken = 1'b0;
    repeat (4) step();
`endif

    // Random phase
    base = n_pop;
    since = 0;
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      reset = 1'b0;
      br_taken = 1'b0;
      ds_allowin = $urandom_range(0, 3) != 0;
      since++;
      if (r == 0) begin
        reset = 1'b1;
        redirect_model(RESET_PC);
        since = 0;
      end else if (r < 6 || since >= 200) begin
        br_taken = 1'b1;
        if (r == 5)
          br_target = 32'hfffffff0;
        else
          br_target = 32'h1c000000
                    + ($urandom_range(0, 4095) << 2);
        redirect_model(br_target);
        since = 0;
      end
      step();
    end
    reset = 1'b0;
    br_taken = 1'b0;
    ds_allowin = 1'b1;
    repeat (4) step();
    check("pop_rate", {31'b0, (n_pop - base) >= 1000}, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
